// File: rtl/quick_cpu_pkg.sv
// Shared definitions for the quick_cpu program loader.
// Frame header constant, loader states and frame-length limit.
package quick_cpu_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    // Legal LEN is 1..2**aw inclusive.
    function automatic logic len_ok(input logic [7:0] b, input int aw);
        return (b != 8'h00) && (int'(b) <= (1 << aw));
    endfunction

endpackage

// File: rtl/quick_cpu_stb_sync.sv
// Two-flop synchroniser for the async byte strobe plus a
// delay flop; emits a one-cycle pulse per rising edge.
module quick_cpu_stb_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/quick_cpu_loader.sv
// Frame loader: receives SYNC/LEN/data/CSUM bytes, writes program
// RAM and holds the CPU in reset until a verified frame lands.
module quick_cpu_loader
    import quick_cpu_pkg::*;
#(
    parameter int         ADDR_W = 4,
    parameter logic [7:0] SYNC   = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        in_data,
    input  logic              in_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int LW = ADDR_W + 1;

    ld_state_t         state, state_n;
    logic [LW-1:0]     len, len_n;
    logic [LW-1:0]     count, count_n;
    logic [7:0]        csum, csum_n;
    logic              hold_n;
    logic              wr_pend, wr_pend_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [7:0]        wr_data, wr_data_n;
    logic              stb;

    quick_cpu_stb_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (in_stb),
        .pulse    (stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            count    <= '0;
            csum     <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            count    <= count_n;
            csum     <= csum_n;
            cpu_hold <= hold_n;
            done     <= (state_n == ST_DONE);
            err      <= (state_n == ST_ERR);
            wr_pend  <= wr_pend_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
        end
    end

    // Output write stage; a pending write survives a load_en drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we    <= wr_pend;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
        end
    end

    always_comb begin
        state_n   = state;
        len_n     = len;
        count_n   = count;
        csum_n    = csum;
        hold_n    = cpu_hold;
        wr_pend_n = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        case (state)
            ST_IDLE: begin
                if (stb && load_en && in_data == SYNC) begin
                    state_n = ST_LEN;
                    hold_n  = 1'b1;
                end
            end
            ST_LEN: begin
                if (!load_en) begin
                    state_n = ST_ERR;
                end else if (stb) begin
                    if (!len_ok(in_data, ADDR_W)) begin
                        state_n = ST_ERR;
                    end else begin
                        len_n   = LW'(in_data);
                        count_n = '0;
                        csum_n  = '0;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!load_en) begin
                    state_n = ST_ERR;
                end else if (stb) begin
                    wr_pend_n = 1'b1;
                    wr_addr_n = count[ADDR_W-1:0];
                    wr_data_n = in_data;
                    csum_n    = csum ^ in_data;
                    count_n   = count + LW'(1);
                    if (count + LW'(1) == len)
                        state_n = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (!load_en) begin
                    state_n = ST_ERR;
                end else if (stb) begin
                    if (in_data == csum) begin
                        state_n = ST_DONE;
                        hold_n  = 1'b0;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                if (!load_en)
                    state_n = ST_IDLE;
            end
            ST_ERR: begin
                if (!load_en)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_quick_cpu_loader.sv
// Scoreboard bench for quick_cpu_loader: expected RAM writes are
// queued by stimulus and popped by a negedge monitor.
module tb_quick_cpu_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [7:0] in_data;
    logic       in_stb;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fr[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    quick_cpu_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .in_data   (in_data),
        .in_stb    (in_stb),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One byte: strobe high 3 clk, low 4 clk; lat = first
    // negedge (counted from the strobe rise) that shows mem_we.
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat = 0;
        @(negedge clk);
        in_data = b;
        in_stb  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we && lat == 0)
                lat = k;
            if (k == 3)
                in_stb = 1'b0;
        end
    endtask

    task automatic send_frame();
        int lat;
        for (int i = 0; i < fr.size(); i++)
            send_byte(fr[i], lat);
    endtask

    task automatic drop_load();
        @(negedge clk);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int lat;
        rst     = 1'b1;
        load_en = 1'b0;
        in_data = 8'h00;
        in_stb  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b0;
        load_en = 1'b1;

        // 1: good 3-byte frame, latency check on each write
        send_byte(8'hA5, lat);
        check("t1_hold_on", 32'(cpu_hold), 32'd1);
        send_byte(8'h03, lat);
        exp_wr(4'd0, 8'h11);
        exp_wr(4'd1, 8'h22);
        exp_wr(4'd2, 8'h33);
        send_byte(8'h11, lat);
        check("t1_lat0", 32'(lat), 32'd4);
        send_byte(8'h22, lat);
        check("t1_lat1", 32'(lat), 32'd4);
        send_byte(8'h33, lat);
        check("t1_lat2", 32'(lat), 32'd4);
        send_byte(8'h00, lat);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err",  32'(err), 32'd0);
        check("t1_hold_off", 32'(cpu_hold), 32'd0);
        wr_drained("t1_writes");
        drop_load();
        check("t1_done_clr", 32'(done), 32'd0);

        // 2: bad checksum
        load_en = 1'b1;
        exp_wr(4'd0, 8'h0F);
        exp_wr(4'd1, 8'hF0);
        fr = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
        send_frame();
        check("t2_err",  32'(err), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        wr_drained("t2_writes");
        drop_load();
        check("t2_err_clr", 32'(err), 32'd0);
        check("t2_hold_kept", 32'(cpu_hold), 32'd1);

        // 3: junk then max-length frame
        load_en = 1'b1;
        fr = '{8'h00, 8'h7E, 8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) begin
            fr.push_back(8'(i));
            exp_wr(4'(i), 8'(i));
        end
        fr.push_back(8'h00);
        send_frame();
        check("t3_done", 32'(done), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        wr_drained("t3_writes");
        drop_load();

        // 4: illegal lengths, no writes expected
        load_en = 1'b1;
        fr = '{8'hA5, 8'h11};
        send_frame();
        check("t4_err17", 32'(err), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd1);
        drop_load();
        load_en = 1'b1;
        fr = '{8'hA5, 8'h00};
        send_frame();
        check("t4_err0", 32'(err), 32'd1);
        wr_drained("t4_writes");
        drop_load();

        // 5: load_en falls mid-data
        load_en = 1'b1;
        exp_wr(4'd0, 8'hAA);
        exp_wr(4'd1, 8'hBB);
        fr = '{8'hA5, 8'h04, 8'hAA, 8'hBB};
        send_frame();
        check("t5_err_pre", 32'(err), 32'd0);
        load_en = 1'b0;
        @(negedge clk);
        check("t5_err", 32'(err), 32'd1);
        repeat (10) @(negedge clk);
        wr_drained("t5_writes");

        // 6: reset during DATA, then a clean frame
        load_en = 1'b1;
        exp_wr(4'd0, 8'h01);
        exp_wr(4'd1, 8'h02);
        fr = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_frame();
        rst = 1'b1;
        @(negedge clk);
        check("t6_we",   32'(mem_we), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'd0);
        check("t6_data", 32'(mem_wdata), 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err",  32'(err), 32'd0);
        rst = 1'b0;
        wr_drained("t6_writes_a");
        exp_wr(4'd0, 8'h05);
        exp_wr(4'd1, 8'h06);
        fr = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h03};
        send_frame();
        check("t6_done2", 32'(done), 32'd1);
        check("t6_hold2", 32'(cpu_hold), 32'd0);
        wr_drained("t6_writes_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
